fan_adder_node_pipe: RTL and testbench
======================================

FAN_ADDER_NODE_PIPE -- requirements
Module: fan_adder_node_pipe

Interface
REQ-001 The parameters SHALL be as follows, one per line:
- DW_DATA, 8: data field width.
- DW_ROW, 4: row tag width.
- DW_CTRL, 4: control field width; fixed at 4.
- NUM_IN, 6: lane count; even, >=2.
- SYMMETRY, 0: destination lane for the unbounded merge (0=left, 1=right).
- SAT_EN, 0: 1=signed saturating add, 0=wrapping add.
- CNT_W, 16: merge counter width.
REQ-002 DW_LINE SHALL equal DW_DATA+DW_ROW+DW_CTRL; the lane layout SHALL be {ctrl,row,data}, with data in the LSBs.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat.
- in  in  NUM_IN*DW_LINE  lane i at [i*DW_LINE +: DW_LINE].
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out  out  NUM_IN*DW_LINE  output lanes.
- merge_cnt  out  CNT_W  count of merges performed, saturating.
- ovf  out  1  sticky: a saturation occurred.
- err_multi  out  1  sticky: more than one valid lane in a group.
REQ-004 Reset SHALL be rst, synchronous, active-high; the clock SHALL be clk.

Function
REQ-005 Control bits SHALL be: ctrl[3]=valid, ctrl[2]=keep, ctrl[1:0]=boundary code.
REQ-006 The left group SHALL be lanes 0..NUM_IN/2-1 and the right group SHALL be lanes NUM_IN/2..NUM_IN-1.
REQ-007 OUT_L SHALL be NUM_IN/2-1 and OUT_R SHALL be NUM_IN/2.
REQ-008 The group candidate SHALL be the bitwise OR of all group lanes whose ctrl[3]=1; a group with no valid lane SHALL yield all-zero.
REQ-009 A merge SHALL occur when both candidates have valid=1 and equal row fields; otherwise the beat SHALL bypass with out equal to in.
REQ-010 The merge output code SHALL follow the boundary codes (L=left candidate ctrl[1:0], R=right candidate ctrl[1:0]):
- L=01 and R=10: OUT_L={0111,row,sum}.
- L=01 only: OUT_R={1001,row,sum}.
- R=10 only: OUT_L={1010,row,sum}.
- Neither: {1000,row,sum} to OUT_L if SYMMETRY=0, else to OUT_R.
- The other OUT lane SHALL be zero in every case.
REQ-011 On a merge, every lane other than OUT_L and OUT_R SHALL pass its input if its ctrl[2]=1, else it SHALL be zero.
REQ-012 With SAT_EN=0, sum SHALL be (L.data+R.data) mod 2^DW_DATA.
REQ-013 With SAT_EN=1, sum SHALL be the signed sum clamped to [-2^(DW_DATA-1), 2^(DW_DATA-1)-1], and ovf SHALL set when the clamp engages.
REQ-014 err_multi SHALL set when a group has two or more lanes with ctrl[3]=1 on an accepted beat; the OR result SHALL still be used.
REQ-015 Handshake SHALL be as follows:
- Single output register stage.
- in_ready = !out_valid || out_ready.
- A beat SHALL be accepted when in_valid && in_ready.
- Latency SHALL be 1 cycle from acceptance to out_valid.
REQ-016 While out_valid=1 and out_ready=0, out SHALL hold stable.
REQ-017 Simultaneous output drain and new acceptance SHALL load the new beat with no bubble.
REQ-018 merge_cnt SHALL increment once per accepted merge beat, saturate at all-ones and never wrap.
REQ-019 Sticky flags, merge_cnt and the output beat SHALL update only on accepted beats.

Reset
REQ-020 On rst=1 at a clk edge, out SHALL clear to 0, out_valid to 0, merge_cnt to 0, ovf to 0 and err_multi to 0.
REQ-021 in_ready SHALL be 1 in the cycle after reset.
REQ-022 A beat pending at reset SHALL be discarded; rst SHALL take priority over acceptance in the same cycle.

Structure
REQ-023 Package fan_pkg SHALL hold the ctrl bit indices, the output codes 0111/1001/1010/1000, the boundary codes 01/10, and the field-offset helper constants.
REQ-024 Sub-module fan_group_select (parameterised lane count; OR-reduce plus multi-valid detect) SHALL be instantiated once per group.

Verification
REQ-025 Defaults apply unless stated. Scenarios:
- Exact merge: lane2={1001,3,5}, lane3={1010,3,7}, others 0 -> next cycle lane2={0111,3,12}, lane3=0, merge_cnt=1.
- Row mismatch / keep filter: lane1={1000,2,9}, lane4={1000,5,4} -> bypass. Then lane1 row=5 and lane0={0100,0,1}: lane0 kept, lane1=0, OUT_L={1000,5,13}.
- Saturation, SAT_EN=1: data 100+100 -> sum 127, ovf=1; -100+-100 -> sum -128. With SAT_EN=0, 100+100 -> sum 200 (0xC8).
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out stable, merge_cnt unchanged. When out_ready=1, back-to-back beats drain one per cycle.
- Multi-valid: lanes 0 and 1 both valid -> err_multi=1 and stays set until reset.
- Reset mid-stream: rst asserted with out_valid=1 -> next cycle out_valid=0, all counters/flags 0. CNT_W=2: after 5 merges merge_cnt=3.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared field layout and code constants for the fan adder node.
// A lane is {ctrl, row, data}, with data in the LSBs.
package fan_pkg;

    localparam int CTRL_W     = 4;

    // Bit positions inside the ctrl field
    localparam int CTRL_VALID = 3;
    localparam int CTRL_KEEP  = 2;

    // Boundary codes carried in ctrl[1:0] of a group candidate
    localparam logic [1:0] BND_LEFT  = 2'b01;
    localparam logic [1:0] BND_RIGHT = 2'b10;

    // Output ctrl codes for the merged lane
    localparam logic [3:0] CODE_BOTH  = 4'b0111;
    localparam logic [3:0] CODE_LEFT  = 4'b1001;
    localparam logic [3:0] CODE_RIGHT = 4'b1010;
    localparam logic [3:0] CODE_NONE  = 4'b1000;

    // Offset of the row field within a lane
    function automatic int row_lsb(input int dw_data);
        return dw_data;
    endfunction

    // Offset of the ctrl field within a lane
    function automatic int ctrl_lsb(input int dw_data, input int dw_row);
        return dw_data + dw_row;
    endfunction

endpackage

// File: rtl/fan_group_select.sv
// Reduces one lane group to a single candidate: OR of all lanes whose
// valid bit is set, plus a flag when two or more lanes were valid.
module fan_group_select
    import fan_pkg::*;
#(
    parameter int N_LANES = 3,
    parameter int DW_DATA = 8,
    parameter int DW_ROW  = 4
) (
    input  logic [N_LANES*(DW_DATA+DW_ROW+CTRL_W)-1:0] lanes_i,
    output logic [DW_DATA+DW_ROW+CTRL_W-1:0]           cand_o,
    output logic                                       multi_o
);

    localparam int DW_LINE   = DW_DATA + DW_ROW + CTRL_W;
    localparam int VALID_BIT = ctrl_lsb(DW_DATA, DW_ROW) + CTRL_VALID;

    logic seen;

    // OR-reduce the valid lanes and flag any second valid lane
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        cand_o  = '0;
        multi_o = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            if (lanes_i[i*DW_LINE + VALID_BIT]) begin
                if (seen) begin
                    multi_o = 1'b1;
                end
                seen   = 1'b1;
                cand_o = cand_o | lanes_i[i*DW_LINE +: DW_LINE];
            end
        end
    end

endmodule

// File: rtl/fan_adder_node_pipe.sv
// Fan adder node: merges the left and right group candidates into one
// lane when their rows match, otherwise passes the beat through.
// One registered output stage with valid/ready flow control.
module fan_adder_node_pipe
    import fan_pkg::*;
#(
    parameter int DW_DATA  = 8,
    parameter int DW_ROW   = 4,
    parameter int DW_CTRL  = 4,
    parameter int NUM_IN   = 6,
    parameter int SYMMETRY = 0,
    parameter int SAT_EN   = 0,
    parameter int CNT_W    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_IN*(DW_DATA+DW_ROW+DW_CTRL)-1:0] in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_IN*(DW_DATA+DW_ROW+DW_CTRL)-1:0] out,
    output logic [CNT_W-1:0]                      merge_cnt,
    output logic                                  ovf,
    output logic                                  err_multi
);

    localparam int DW_LINE  = DW_DATA + DW_ROW + DW_CTRL;
    localparam int HALF     = NUM_IN / 2;
    localparam int OUT_L    = HALF - 1;
    localparam int OUT_R    = HALF;
    localparam int ROW_LSB  = row_lsb(DW_DATA);
    localparam int CTRL_LSB = ctrl_lsb(DW_DATA, DW_ROW);

    logic [DW_LINE-1:0]        cand_l, cand_r;
    logic                      multi_l, multi_r;
    logic                      accept, is_merge, sat_hit;
    logic [DW_DATA:0]          wide_sum;
    logic [DW_DATA-1:0]        sum;
    logic [NUM_IN*DW_LINE-1:0] out_d, out_q;
    logic                      out_valid_q;
    logic [CNT_W-1:0]          merge_cnt_q;
    logic                      ovf_q, err_multi_q;
    logic [DW_LINE-1:0]        lane;
    logic [1:0]                bnd_l, bnd_r;

    fan_group_select #(.N_LANES(HALF), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW)) u_sel_l (
        .lanes_i (in[HALF*DW_LINE-1:0]),
        .cand_o  (cand_l),
        .multi_o (multi_l)
    );

    fan_group_select #(.N_LANES(NUM_IN-HALF), .DW_DATA(DW_DATA), .DW_ROW(DW_ROW)) u_sel_r (
        .lanes_i (in[NUM_IN*DW_LINE-1:HALF*DW_LINE]),
        .cand_o  (cand_r),
        .multi_o (multi_r)
    );

    // The keep bits of the candidates carry no meaning after the OR.
    logic unused_cand_keep;
    assign unused_cand_keep = cand_l[CTRL_LSB+CTRL_KEEP] ^ cand_r[CTRL_LSB+CTRL_KEEP];

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign bnd_l    = cand_l[CTRL_LSB +: 2];
    assign bnd_r    = cand_r[CTRL_LSB +: 2];
    assign is_merge = cand_l[CTRL_LSB+CTRL_VALID] && cand_r[CTRL_LSB+CTRL_VALID]
                      && (cand_l[ROW_LSB +: DW_ROW] == cand_r[ROW_LSB +: DW_ROW]);

    // Sign-extended add; overflow when the top two bits disagree
    assign wide_sum = {cand_l[DW_DATA-1], cand_l[DW_DATA-1:0]}
                    + {cand_r[DW_DATA-1], cand_r[DW_DATA-1:0]};
    assign sat_hit  = (SAT_EN != 0) && (wide_sum[DW_DATA] != wide_sum[DW_DATA-1]);
    assign sum      = !sat_hit            ? wide_sum[DW_DATA-1:0] :
                      wide_sum[DW_DATA]   ? {1'b1, {(DW_DATA-1){1'b0}}} :
                                            {1'b0, {(DW_DATA-1){1'b1}}};

    // Build the next output beat: bypass, or merge with keep filtering
    always_comb begin
        out_d = in;
        lane  = '0;
        if (is_merge) begin
            for (int i = 0; i < NUM_IN; i++) begin
                lane = in[i*DW_LINE +: DW_LINE];
                out_d[i*DW_LINE +: DW_LINE] = lane[CTRL_LSB+CTRL_KEEP] ? lane : '0;
            end
            out_d[OUT_L*DW_LINE +: DW_LINE] = '0;
            out_d[OUT_R*DW_LINE +: DW_LINE] = '0;
            if (bnd_l == BND_LEFT && bnd_r == BND_RIGHT) begin
                out_d[OUT_L*DW_LINE +: DW_LINE] = {CODE_BOTH, cand_l[ROW_LSB +: DW_ROW], sum};
            end else if (bnd_l == BND_LEFT) begin
                out_d[OUT_R*DW_LINE +: DW_LINE] = {CODE_LEFT, cand_l[ROW_LSB +: DW_ROW], sum};
            end else if (bnd_r == BND_RIGHT) begin
                out_d[OUT_L*DW_LINE +: DW_LINE] = {CODE_RIGHT, cand_l[ROW_LSB +: DW_ROW], sum};
            end else if (SYMMETRY == 0) begin
                out_d[OUT_L*DW_LINE +: DW_LINE] = {CODE_NONE, cand_l[ROW_LSB +: DW_ROW], sum};
            end else begin
                out_d[OUT_R*DW_LINE +: DW_LINE] = {CODE_NONE, cand_l[ROW_LSB +: DW_ROW], sum};
            end
        end
    end

    // Output register, merge counter and sticky flags; reset wins over accept
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            merge_cnt_q <= '0;
            ovf_q       <= 1'b0;
            err_multi_q <= 1'b0;
        end else begin
            if (accept) begin
                out_q       <= out_d;
                out_valid_q <= 1'b1;
                if (is_merge && merge_cnt_q != '1) begin
                    merge_cnt_q <= merge_cnt_q + 1'b1;
                end
                if (is_merge && sat_hit) begin
                    ovf_q <= 1'b1;
                end
                if (multi_l || multi_r) begin
                    err_multi_q <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign merge_cnt = merge_cnt_q;
    assign ovf       = ovf_q;
    assign err_multi = err_multi_q;

endmodule

// File: tb/tb_fan_adder_node_pipe.sv
// Bench for fan_adder_node_pipe: a default instance and a saturating
// instance with a 2-bit merge counter share the same stimulus.
module tb_fan_adder_node_pipe;

    localparam int W = 96;

    logic         clk = 1'b0;
    logic         rst, in_valid, out_ready;
    logic [W-1:0] in_bus;
    logic         in_ready0, in_ready1, out_valid0, out_valid1;
    logic [W-1:0] out0, out1;
    logic [15:0]  cnt0;
    logic [1:0]   cnt1;
    logic         ovf0, ovf1, em0, em1;

    always #5 clk = ~clk;

    fan_adder_node_pipe dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in(in_bus),
        .out_valid(out_valid0), .out_ready(out_ready), .out(out0),
        .merge_cnt(cnt0), .ovf(ovf0), .err_multi(em0)
    );

    fan_adder_node_pipe #(.SAT_EN(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in(in_bus),
        .out_valid(out_valid1), .out_ready(out_ready), .out(out1),
        .merge_cnt(cnt1), .ovf(ovf1), .err_multi(em1)
    );

    typedef struct {
        string        name;
        logic [W-1:0] lanes;
        logic [W-1:0] exp0;
        logic [W-1:0] exp1;
        bit           merge;
        bit           sat;
        bit           multi;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] exp0;
        logic [W-1:0] exp1;
        int unsigned  cnt0;
        int unsigned  cnt1;
        bit           ovf1;
        bit           multi;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sbq[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned m_cnt0, m_cnt1;
    bit          m_ovf1, m_multi;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [W-1:0] lanes, input logic [W-1:0] e0,
                           input logic [W-1:0] e1, input bit m, input bit s, input bit mu);
        vec_t v;
        v.name = name; v.lanes = lanes; v.exp0 = e0; v.exp1 = e1;
        v.merge = m; v.sat = s; v.multi = mu;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_cnt0 = 0; m_cnt1 = 0; m_ovf1 = 1'b0; m_multi = 1'b0;
        sbq.delete();
    endtask

    task automatic push_expect(input int k);
        sb_t e;
        if (vecs[k].merge) begin
            if (m_cnt0 != 65535) m_cnt0++;
            if (m_cnt1 != 3) m_cnt1++;
        end
        m_ovf1  = m_ovf1 | vecs[k].sat;
        m_multi = m_multi | vecs[k].multi;
        e.name = vecs[k].name; e.exp0 = vecs[k].exp0; e.exp1 = vecs[k].exp1;
        e.cnt0 = m_cnt0; e.cnt1 = m_cnt1; e.ovf1 = m_ovf1; e.multi = m_multi;
        sbq.push_back(e);
    endtask

    // Drive one beat from the table; returns one cycle after acceptance
    task automatic send(input int k);
        int waited = 0;
        in_bus   = vecs[k].lanes;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready0) begin
                push_expect(k);
                break;
            end
            waited++;
            if (waited > 20) begin
                checks++; errors++;
                $display("FAIL accept_timeout_%s: got in_ready=0 for %0d cycles expected acceptance", vecs[k].name, waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Compare the head of the scoreboard with whatever the outputs present
    always @(negedge clk) begin
        if (!rst && out_valid0) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: got out_valid=1 expected no beat");
            end else begin
                check({sbq[0].name, "_out_wrap"}, out0, sbq[0].exp0);
                check({sbq[0].name, "_out_sat"}, out1, sbq[0].exp1);
                check({sbq[0].name, "_valid_sat"}, out_valid1, 1'b1);
                check({sbq[0].name, "_cnt16"}, cnt0, sbq[0].cnt0[15:0]);
                check({sbq[0].name, "_cnt2"}, cnt1, sbq[0].cnt1[1:0]);
                check({sbq[0].name, "_ovf_wrap"}, ovf0, 1'b0);
                check({sbq[0].name, "_ovf_sat"}, ovf1, sbq[0].ovf1);
                check({sbq[0].name, "_err_multi"}, em0, sbq[0].multi);
                check({sbq[0].name, "_err_multi_sat"}, em1, sbq[0].multi);
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, out_valid0, 1'b0);
        check({tag, "_out"}, out0, '0);
        check({tag, "_out_sat"}, out1, '0);
        check({tag, "_cnt16"}, cnt0, 16'd0);
        check({tag, "_cnt2"}, cnt1, 2'd0);
        check({tag, "_ovf"}, ovf1, 1'b0);
        check({tag, "_err_multi"}, em0, 1'b0);
        check({tag, "_in_ready"}, in_ready0, 1'b1);
    endtask

    initial begin
        int cyc_start;

        // Lane order in each literal: lane5 ... lane0, each {ctrl,row,data} as 16 bits
        add_vec("exact_merge",
            {16'h0000, 16'h0000, 16'hA307, 16'h9305, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h730C, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h730C, 16'h0000, 16'h0000}, 1, 0, 0);
        add_vec("row_mismatch",
            {16'h0000, 16'h8504, 16'h0000, 16'h0000, 16'h8209, 16'h0000},
            {16'h0000, 16'h8504, 16'h0000, 16'h0000, 16'h8209, 16'h0000},
            {16'h0000, 16'h8504, 16'h0000, 16'h0000, 16'h8209, 16'h0000}, 0, 0, 0);
        add_vec("keep_filter",
            {16'h0000, 16'h8504, 16'h0000, 16'h0000, 16'h8509, 16'h4001},
            {16'h0000, 16'h0000, 16'h0000, 16'h850D, 16'h0000, 16'h4001},
            {16'h0000, 16'h0000, 16'h0000, 16'h850D, 16'h0000, 16'h4001}, 1, 0, 0);
        add_vec("sat_pos",
            {16'h0000, 16'h0000, 16'h8164, 16'h8164, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h81C8, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h817F, 16'h0000, 16'h0000}, 1, 1, 0);
        add_vec("sat_neg",
            {16'h0000, 16'h0000, 16'h819C, 16'h819C, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h8138, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h8180, 16'h0000, 16'h0000}, 1, 1, 0);
        add_vec("left_only",
            {16'h8203, 16'h4411, 16'h0000, 16'h0000, 16'h0000, 16'h9207},
            {16'h0000, 16'h4411, 16'h920A, 16'h0000, 16'h0000, 16'h0000},
            {16'h0000, 16'h4411, 16'h920A, 16'h0000, 16'h0000, 16'h0000}, 1, 0, 0);
        add_vec("right_only",
            {16'h0000, 16'hA320, 16'h0000, 16'h0000, 16'h8310, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'hA330, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'hA330, 16'h0000, 16'h0000}, 1, 0, 0);
        add_vec("multi_valid",
            {16'h0000, 16'h0000, 16'h8104, 16'h0000, 16'h8102, 16'h8101},
            {16'h0000, 16'h0000, 16'h0000, 16'h8107, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h8107, 16'h0000, 16'h0000}, 1, 0, 1);
        add_vec("one_side",
            {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8101},
            {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8101},
            {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8101}, 0, 0, 0);
        add_vec("wrap_zero",
            {16'h0000, 16'h0000, 16'h8201, 16'h82FF, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h8200, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h8200, 16'h0000, 16'h0000}, 1, 0, 0);
        add_vec("sat_edge",
            {16'h0000, 16'h0000, 16'h8301, 16'h837F, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h8380, 16'h0000, 16'h0000},
            {16'h0000, 16'h0000, 16'h0000, 16'h837F, 16'h0000, 16'h0000}, 1, 1, 0);

        // Reset with junk on the inputs
        model_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_bus = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_bus = '0;
        @(negedge clk);
        check_cleared("reset");
        @(posedge clk);
        #1;

        // Whole table back-to-back: one beat per cycle
        cyc_start = cyc;
        for (int k = 0; k < vecs.size(); k++) send(k);
        check("no_bubble_cycles", cyc - cyc_start, vecs.size());

        // Backpressure: output stalled for 5 cycles with a beat waiting
        out_ready = 1'b0;
        in_bus    = vecs[0].lanes;
        in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", in_ready0, 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(0);
        send(1);
        send(2);

        // Reset while a beat is held and another is pending
        send(3);
        out_ready = 1'b0;
        in_bus    = vecs[4].lanes;
        in_valid  = 1'b1;
        @(negedge clk);
        check("pre_reset_in_ready", in_ready0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check_cleared("mid_reset");
        @(posedge clk);
        #1;

        // Five merges: 2-bit counter saturates at 3, 16-bit counter reaches 5
        for (int n = 0; n < 5; n++) send(0);
        @(negedge clk);
        check("cnt_w2_saturated", cnt1, 2'd3);
        check("cnt_w16_five", cnt0, 16'd5);
        @(posedge clk);
        @(negedge clk);
        check("drained_valid", out_valid0, 1'b0);
        check("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
